// File: rtl/acq_readout_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : acq_readout_if                                               |
// | Description : Control, acquisition-port and DSP-stream signals of the      |
// |               acq_readout sequencer. master = sequencer, slave = peers.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface acq_readout_if #(
    parameter int LEN_W = 12
);
    logic             rd_start;
    logic [LEN_W-1:0] rd_len;
    logic             ram_rdaddr_rst;
    logic             ram_rd_en;
    logic             xrd;
    logic [15:0]      dataout;
    logic [15:0]      dsp_data;
    logic             dsp_valid;
    logic             dsp_ready;
    logic             busy;
    logic             done;
    logic [LEN_W-1:0] words_sent;
    logic [15:0]      checksum;

    modport master (
        input  rd_start, rd_len, dataout, dsp_ready,
        output ram_rdaddr_rst, ram_rd_en, xrd, dsp_data, dsp_valid,
               busy, done, words_sent, checksum
    );

    modport slave (
        output rd_start, rd_len, dataout, dsp_ready,
        input  ram_rdaddr_rst, ram_rd_en, xrd, dsp_data, dsp_valid,
               busy, done, words_sent, checksum
    );
endinterface
`default_nettype wire

// File: rtl/acq_readout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : acq_readout                                                  |
// | Description : Reads a requested number of words from the acquisition port  |
// |               (xrd strobe, 3 cycles/word), buffers them in a FIFO and      |
// |               streams them out with word count and 16-bit checksum.        |
// |               Optional macro ACQ_RD_CHECKSUM_EN adds a checksum trailer.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module acq_readout #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 12
) (
    input  wire logic     clk_sys,
    input  wire logic     rd_reset,
    acq_readout_if.master bus
);

    localparam int                AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]       CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARST   = 3'd1,
        S_SETUP  = 3'd2,
        S_RD_LO1 = 3'd3,
        S_RD_LO2 = 3'd4,
        S_RD_HI  = 3'd5,
        S_DRAIN  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] left_q, left_d;
    logic [LEN_W-1:0] words_q;
    logic             rdaddr_rst_q;
    logic             rd_en_q;
    logic             xrd_q;
    logic             busy_q;
    logic             done_q;

    logic [15:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;

    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;
    logic             space;
    logic             trailer_vld;
    logic             drain_exit;

    assign accept        = (state_q == S_IDLE) && bus.rd_start;
    assign push          = (state_q == S_RD_LO2);
    assign fifo_nonempty = (cnt_q != '0);
    assign pop           = fifo_nonempty && bus.dsp_ready;
    // Only one word can be in flight, so occupancy below depth guarantees room.
    assign space         = (cnt_q < CNT_FULL);

`ifdef ACQ_RD_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk_sys) begin
        if (rd_reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (pop) begin
            sum_q <= sum_q + mem_q[rd_ptr_q];
        end
    end

    // Trailer is presented once all data words have left the FIFO.
    assign trailer_vld  = (state_q == S_DRAIN) && !fifo_nonempty;
    assign drain_exit   = trailer_vld && bus.dsp_ready;
    assign bus.checksum = sum_q;
    assign bus.dsp_data = fifo_nonempty ? mem_q[rd_ptr_q]
                                        : (trailer_vld ? sum_q : 16'h0000);
`else
    assign trailer_vld  = 1'b0;
    assign drain_exit   = !fifo_nonempty || ((cnt_q == CNT_ONE) && pop);
    assign bus.checksum = 16'h0000;
    assign bus.dsp_data = fifo_nonempty ? mem_q[rd_ptr_q] : 16'h0000;
`endif

    assign bus.dsp_valid      = fifo_nonempty || trailer_vld;
    assign bus.ram_rdaddr_rst = rdaddr_rst_q;
    assign bus.ram_rd_en      = rd_en_q;
    assign bus.xrd            = xrd_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.words_sent     = words_q;

    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rd_start) begin
                    left_d  = bus.rd_len;
                    state_d = S_ARST;
                end
            end
            S_ARST:   state_d = (left_q == '0) ? S_DRAIN : S_SETUP;
            S_SETUP:  if (space) state_d = S_RD_LO1;
            S_RD_LO1: state_d = S_RD_LO2;
            S_RD_LO2: begin
                left_d  = left_q - LEN_ONE;
                state_d = S_RD_HI;
            end
            S_RD_HI: begin
                if (left_q == '0) begin
                    state_d = S_DRAIN;
                end else if (space) begin
                    state_d = S_RD_LO1;
                end
            end
            S_DRAIN:  if (drain_exit) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes are registered decodes of the next state so they are glitch-free.
    always_ff @(posedge clk_sys) begin
        if (rd_reset) begin
            state_q      <= S_IDLE;
            left_q       <= '0;
            rdaddr_rst_q <= 1'b0;
            rd_en_q      <= 1'b0;
            xrd_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            left_q       <= left_d;
            rdaddr_rst_q <= (state_d == S_ARST);
            rd_en_q      <= (state_d == S_SETUP)  || (state_d == S_RD_LO1) ||
                            (state_d == S_RD_LO2) || (state_d == S_RD_HI);
            xrd_q        <= !((state_d == S_RD_LO1) || (state_d == S_RD_LO2));
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rd_reset) begin
            words_q <= '0;
        end else if (accept) begin
            words_q <= '0;
        end else if (pop) begin
            words_q <= words_q + LEN_ONE;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.dataout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rd_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule
`default_nettype wire
